// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word reads, buffers returned words in a
// 2-entry FIFO for the decoder, and handles redirects and misaligned-target faults.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_read_address,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_read_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fault,
    output logic [31:0] fault_pc
);

    typedef enum logic [0:0] {StRun, StFault} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [1:0]  count_q, count_d;
    // Each entry is {instr, pc}; entry 0 is the head.
    logic [63:0] entry0_q, entry0_d;
    logic [63:0] entry1_q, entry1_d;

    logic [31:0] read_addr;
    logic        transfer;
    logic [1:0]  count_after_pop;
    logic        aligned_redirect;
    logic        issue;
    logic        push;

    assign read_addr = redirect_valid ? redirect_pc : fetch_pc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StRun;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'd0;
            fault_pc_q    <= 32'd0;
            count_q       <= 2'd0;
            entry0_q      <= 64'd0;
            entry1_q      <= 64'd0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            fault_pc_q    <= fault_pc_d;
            count_q       <= count_d;
            entry0_q      <= entry0_d;
            entry1_q      <= entry1_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        inflight_pc_d    = inflight_pc_q;
        fault_pc_d       = fault_pc_q;
        entry0_d         = entry0_q;
        entry1_d         = entry1_q;
        transfer         = (count_q != 2'd0) && instr_ready;
        count_after_pop  = count_q - {1'b0, transfer};
        aligned_redirect = redirect_valid && (redirect_pc[1:0] == 2'b00);
        // Credit check keeps buffered plus in-flight words within FIFO capacity.
        issue = aligned_redirect ||
                (!redirect_valid && (state_q == StRun) &&
                 (({1'b0, count_after_pop} + {2'b00, inflight_q}) < 3'd2));
        push  = inflight_q && !redirect_valid;

        count_d = count_after_pop;
        if (transfer) begin
            entry0_d = entry1_q;
        end
        if (push) begin
            if (count_after_pop == 2'd0) begin
                entry0_d = {mem_read_data, inflight_pc_q};
            end else begin
                entry1_d = {mem_read_data, inflight_pc_q};
            end
            count_d = count_after_pop + 2'd1;
        end

        if (redirect_valid) begin
            count_d = 2'd0;
            if (aligned_redirect) begin
                state_d    = StRun;
                fault_pc_d = 32'd0;
            end else begin
                state_d    = StFault;
                fault_pc_d = redirect_pc;
            end
        end

        inflight_d = issue;
        if (issue) begin
            inflight_pc_d = read_addr;
            fetch_pc_d    = read_addr + 32'd4;
        end
    end

    always_comb begin
        mem_read_address = read_addr;
        mem_funct3       = 3'b010;
        instr_valid      = (count_q != 2'd0);
        instr            = instr_valid ? entry0_q[63:32] : 32'd0;
        instr_pc         = instr_valid ? entry0_q[31:0] : 32'd0;
        fault            = (state_q == StFault);
        fault_pc         = fault ? fault_pc_q : 32'd0;
    end

endmodule
